proc_run_ctrl: RTL and testbench
================================

# proc_run_ctrl

Run controller that sequences the RISCprocessor core: it holds the core in reset, releases it, and gates its clock enable through run, pause, single-step and finish phases. It sits between the system/bench control logic and the core's `Reset` and clock-enable inputs. It also counts executed cycles and terminates a run on a core halt indication or a programmable cycle limit.

## Interface
- `CNT_W`, 16, width of the cycle counter and `run_limit`.
- `RESET_CYCLES`, 4, number of cycles `cpu_reset` is held after `start` (≥1).

- `clk`  input  1  system clock; single clock domain.
- `Reset`  input  1  synchronous, active-high reset.
- `start`  input  1  begin a run; sampled only in IDLE or DONE.
- `pause`  input  1  request pause; honoured in RUN.
- `resume`  input  1  leave PAUSE and re-enter RUN.
- `step`  input  1  execute exactly one core cycle from PAUSE.
- `abort`  input  1  return to IDLE from any busy state or DONE.
- `run_limit`  input  CNT_W  maximum enabled cycles per run; 0 = unlimited.
- `halt_in`  input  1  core halt indication; sampled only when `cpu_clk_en`=1.
- `cpu_reset`  output  1  drives the core's `Reset`.
- `cpu_clk_en`  output  1  core clock enable.
- `state`  output  3  IDLE=0, RST=1, RUN=2, PAUSE=3, STEP=4, DONE=5.
- `busy`  output  1  high in RST, RUN, PAUSE, STEP.
- `done`  output  1  one-cycle pulse on the first cycle in DONE.
- `timeout`  output  1  sticky; run ended by `run_limit`; cleared by `start` or `abort`.
- `cycle_count`  output  CNT_W  number of enabled core cycles in the current run.

## Operation
- Moore FSM. `cpu_reset` and `cpu_clk_en` decode from the registered state only:
  - `cpu_reset`=1 in IDLE and RST, else 0.
  - `cpu_clk_en`=1 in RUN and STEP only.
- IDLE: `start` → RST. Clears `cycle_count`, `timeout` and the reset-hold counter.
- RST: the hold counter runs for RESET_CYCLES cycles, then → RUN.
- RUN: `cycle_count` increments every cycle. Next state by priority:
  - `abort` → IDLE.
  - `halt_in` → DONE.
  - `run_limit`≠0 and `cycle_count`+1 == `run_limit` → DONE, with `timeout` set.
  - `pause` → PAUSE.
  - Otherwise stay in RUN.
- PAUSE: core frozen, not in reset. Priority: `abort` > `resume` (→ RUN) > `step` (→ STEP).
- STEP: lasts one cycle with `cycle_count` incremented. Then, with the same priority as RUN: `abort` → IDLE, `halt_in` → DONE, limit → DONE with timeout, otherwise → PAUSE. `pause`/`step` held during STEP are ignored.
- DONE: core frozen, not in reset, so its state stays inspectable. `start` → RST (new run); `abort` → IDLE.
- `start` is ignored while `busy`.
- `cycle_count` saturates at 2^CNT_W−1 and never wraps. Unlimited runs continue at saturation.
- `halt_in` and the limit hit in the same cycle: DONE with `timeout`=0 (halt wins).
- `abort` and `start` in the same DONE cycle: `abort` wins.

## Timing
- Reset values (cycle after `Reset` sampled high): state=IDLE, `cpu_reset`=1, `cpu_clk_en`=0, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0. `Reset` overrides every input, including mid-run.
- `start` sampled at edge t:
  - RST occupies cycles t+1 … t+RESET_CYCLES.
  - First `cpu_clk_en`=1 is cycle t+RESET_CYCLES+1.
- Control inputs sampled at edge e take effect from cycle e+1. `cpu_clk_en` drops in the cycle after `pause`, `halt_in` or the limit is sampled.
- Enabled cycles per limited run equal exactly `run_limit`.
- `cycle_count` updates at the end of each enabled cycle, so it equals the number of completed enabled cycles.
- `done` is high exactly one cycle, coincident with the first DONE cycle.

## Test plan
- RESET_CYCLES=4, `run_limit`=0, `start` pulse, `halt_in` asserted in the 10th enabled cycle → `cpu_reset` high 4 cycles after start, 10 `cpu_clk_en` cycles, DONE, `done` pulses once, `cycle_count`=10, `timeout`=0.
- `run_limit`=20, `halt_in`=0 → exactly 20 enabled cycles, DONE, `timeout`=1, `cycle_count`=20. A following `start` clears `timeout` and `cycle_count`.
- Run with `pause` after 5 enabled cycles, then three `step` pulses, then `resume` → `cpu_clk_en` high exactly one cycle per step, `cycle_count`=8 on entering RUN again.
- `run_limit`=7, `halt_in` asserted in the 7th enabled cycle → DONE, `timeout`=0, `cycle_count`=7.
- `abort` in RUN and again in PAUSE → IDLE next cycle with `cpu_reset`=1. `Reset` asserted mid-RUN → all outputs at reset values next cycle. `start` during RUN → no effect.
- CNT_W=4, `run_limit`=0, no halt for 30 cycles → `cycle_count` stops at 15, `cpu_clk_en` stays 1, no DONE.

Source files
------------

// File: rtl/proc_run_ctrl.sv
// Run controller for the RISC core: sequences core reset, run/pause/step/finish
// phases, counts enabled core cycles and ends a run on halt or a cycle limit.
module proc_run_ctrl #(
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             pause,
  input  logic             resume,
  input  logic             step,
  input  logic             abort,
  input  logic [CNT_W-1:0] run_limit,
  input  logic             halt_in,
  output logic             cpu_reset,
  output logic             cpu_clk_en,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    STEP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_r;
  state_t            nextState_s;
  logic [HOLD_W-1:0] holdCnt_r;
  logic [CNT_W-1:0]  cycleCount_r;
  logic              timeout_r;
  logic              cpuReset_r;
  logic              cpuClkEn_r;
  logic              busy_r;
  logic              done_r;
  logic [CNT_W:0]    countPlusOne_s;
  logic              limitHit_s;
  logic              enabled_s;
  logic              setTimeout_s;
  logic              clearRun_s;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  // Limit detection; extra bit keeps the compare exact at the counter ceiling
  always_comb begin
    countPlusOne_s = {1'b0, cycleCount_r} + {{CNT_W{1'b0}}, 1'b1};
    limitHit_s     = (run_limit != {CNT_W{1'b0}}) &&
                     (countPlusOne_s == {1'b0, run_limit});
    enabled_s      = (state_r == RUN) || (state_r == STEP);
  end

  // Next-state logic; RUN and STEP share the abort > halt > limit priority
  always_comb begin
    nextState_s  = state_r;
    setTimeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) nextState_s = RST;
        else       nextState_s = IDLE;
      end
      RST: begin
        if (abort)                        nextState_s = IDLE;
        else if (holdCnt_r == HOLD_LAST)  nextState_s = RUN;
        else                              nextState_s = RST;
      end
      RUN, STEP: begin
        if (abort) begin
          nextState_s = IDLE;
        end else if (halt_in) begin
          nextState_s = DONE;
        end else if (limitHit_s) begin
          nextState_s  = DONE;
          setTimeout_s = 1'b1;
        end else if (state_r == STEP) begin
          nextState_s = PAUSE;
        end else if (pause) begin
          nextState_s = PAUSE;
        end else begin
          nextState_s = RUN;
        end
      end
      PAUSE: begin
        if (abort)       nextState_s = IDLE;
        else if (resume) nextState_s = RUN;
        else if (step)   nextState_s = STEP;
        else             nextState_s = PAUSE;
      end
      DONE: begin
        if (abort)      nextState_s = IDLE;
        else if (start) nextState_s = RST;
        else            nextState_s = DONE;
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Entering IDLE or RST wipes the per-run statistics
  always_comb begin
    if ((nextState_s == IDLE) || (nextState_s == RST)) clearRun_s = 1'b1;
    else                                               clearRun_s = 1'b0;
  end

  // State, reset-hold counter and run statistics
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r      <= IDLE;
      holdCnt_r    <= {HOLD_W{1'b0}};
      cycleCount_r <= {CNT_W{1'b0}};
      timeout_r    <= 1'b0;
    end else begin
      state_r <= nextState_s;
      if (state_r == RST) holdCnt_r <= holdCnt_r + HOLD_W'(1'b1);
      else                holdCnt_r <= {HOLD_W{1'b0}};
      if (clearRun_s)     cycleCount_r <= {CNT_W{1'b0}};
      else if (enabled_s) cycleCount_r <= satInc(cycleCount_r);
      else                cycleCount_r <= cycleCount_r;
      if (clearRun_s)        timeout_r <= 1'b0;
      else if (setTimeout_s) timeout_r <= 1'b1;
      else                   timeout_r <= timeout_r;
    end
  end

  // Output flops decoded from the next state so they match the state register
  always_ff @(posedge clk) begin
    if (Reset) begin
      cpuReset_r <= 1'b1;
      cpuClkEn_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      cpuReset_r <= (nextState_s == IDLE) || (nextState_s == RST);
      cpuClkEn_r <= (nextState_s == RUN) || (nextState_s == STEP);
      busy_r     <= (nextState_s == RST) || (nextState_s == RUN) ||
                    (nextState_s == PAUSE) || (nextState_s == STEP);
      done_r     <= (nextState_s == DONE) && (state_r != DONE);
    end
  end

  assign cpu_reset   = cpuReset_r;
  assign cpu_clk_en  = cpuClkEn_r;
  assign state       = state_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign timeout     = timeout_r;
  assign cycle_count = cycleCount_r;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: a 16-bit counter instance for the run
// scenarios and a 4-bit counter instance for saturation, sharing controls.
module tb_proc_run_ctrl;

  logic        clk = 1'b0;
  logic        Reset, start, pause, resume, step, abort, halt_in;
  logic [15:0] runLimit;
  logic [3:0]  runLimitS;
  logic        cpuReset, cpuClkEn, busy, done, timeout;
  logic [2:0]  state;
  logic [15:0] cycleCount;
  logic        cpuResetS, cpuClkEnS, busyS, doneS, timeoutS;
  logic [2:0]  stateS;
  logic [3:0]  cycleCountS;
  int          total = 0;
  int          bad   = 0;
  int          en;

  localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_RUN = 3'd2,
                         S_PAUSE = 3'd3, S_STEP = 3'd4, S_DONE = 3'd5;

  always #5 clk = ~clk;

  proc_run_ctrl #(.CNT_W(16), .RESET_CYCLES(4)) dut (
    .clk(clk), .Reset(Reset), .start(start), .pause(pause), .resume(resume),
    .step(step), .abort(abort), .run_limit(runLimit), .halt_in(halt_in),
    .cpu_reset(cpuReset), .cpu_clk_en(cpuClkEn), .state(state), .busy(busy),
    .done(done), .timeout(timeout), .cycle_count(cycleCount)
  );

  proc_run_ctrl #(.CNT_W(4), .RESET_CYCLES(4)) dutS (
    .clk(clk), .Reset(Reset), .start(start), .pause(pause), .resume(resume),
    .step(step), .abort(abort), .run_limit(runLimitS), .halt_in(halt_in),
    .cpu_reset(cpuResetS), .cpu_clk_en(cpuClkEnS), .state(stateS), .busy(busyS),
    .done(doneS), .timeout(timeoutS), .cycle_count(cycleCountS)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
    chk({tag, "_cpuReset"}, 32'(cpuReset), 32'd1);
    chk({tag, "_clkEn"}, 32'(cpuClkEn), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_count"}, 32'(cycleCount), 32'd0);
  endtask

  // Pulse start, check the 4 reset-hold cycles, finish in the first RUN cycle
  task automatic startRun(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_rstState"}, 32'(state), 32'(S_RST));
    chk({tag, "_rstCount"}, 32'(cycleCount), 32'd0);
    chk({tag, "_rstTimeout"}, 32'(timeout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_rstHold"}, {30'd0, cpuReset, busy}, 32'd3);
    end
    tick();
    chk({tag, "_runState"}, 32'(state), 32'(S_RUN));
    chk({tag, "_runEn"}, {30'd0, cpuClkEn, cpuReset}, 32'd2);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; pause = 1'b0; resume = 1'b0; step = 1'b0;
    abort = 1'b0; halt_in = 1'b0; runLimit = 16'd0; runLimitS = 4'd0;
    tick();
    tick();
    chkResetVals("reset");
    Reset = 1'b0;

    // Unlimited run halted in the 10th enabled cycle
    startRun("t1");
    en = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      en += int'(cpuClkEn);
    end
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    chk("t1_enCycles", 32'(en), 32'd10);
    chk("t1_state", 32'(state), 32'(S_DONE));
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_count", 32'(cycleCount), 32'd10);
    chk("t1_timeout", 32'(timeout), 32'd0);
    chk("t1_frozen", {30'd0, cpuClkEn, cpuReset}, 32'd0);
    tick();
    chk("t1_donePulse", 32'(done), 32'd0);
    chk("t1_stayDone", 32'(state), 32'(S_DONE));

    // Limit of 20 enabled cycles
    runLimit = 16'd20;
    startRun("t2");
    en = 0;
    for (int i = 0; i < 100 && state != S_DONE; i++) begin
      en += int'(cpuClkEn);
      tick();
    end
    chk("t2_enCycles", 32'(en), 32'd20);
    chk("t2_state", 32'(state), 32'(S_DONE));
    chk("t2_timeout", 32'(timeout), 32'd1);
    chk("t2_count", 32'(cycleCount), 32'd20);
    chk("t2_done", 32'(done), 32'd1);

    // Pause after 5 cycles, three steps, resume (startRun also checks the clear)
    runLimit = 16'd0;
    startRun("t3");
    repeat (4) tick();
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("t3_pauseState", 32'(state), 32'(S_PAUSE));
    chk("t3_pauseCount", 32'(cycleCount), 32'd5);
    chk("t3_pauseOut", {30'd0, cpuClkEn, cpuReset}, 32'd0);
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      tick();
      chk("t3_stepState", 32'(state), 32'(S_STEP));
      chk("t3_stepEn", 32'(cpuClkEn), 32'd1);
      if (s != 0) step = 1'b0;
      tick();
      step = 1'b0;
      chk("t3_backPause", 32'(state), 32'(S_PAUSE));
      chk("t3_backEn", 32'(cpuClkEn), 32'd0);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("t3_resumeState", 32'(state), 32'(S_RUN));
    chk("t3_resumeCount", 32'(cycleCount), 32'd8);

    // start while busy is ignored, then abort in RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_startIgnored", 32'(state), 32'(S_RUN));
    chk("t5_countKept", 32'(cycleCount), 32'd9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abortRun", 32'(state), 32'(S_IDLE));
    chk("t5_abortRunRst", {30'd0, cpuReset, busy}, 32'd2);

    // Halt and limit coincide in the 7th enabled cycle: halt wins
    runLimit = 16'd7;
    startRun("t4");
    repeat (6) tick();
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    chk("t4_state", 32'(state), 32'(S_DONE));
    chk("t4_timeout", 32'(timeout), 32'd0);
    chk("t4_count", 32'(cycleCount), 32'd7);

    // Abort in PAUSE
    runLimit = 16'd0;
    startRun("t6");
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("t6_paused", 32'(state), 32'(S_PAUSE));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abortPause", 32'(state), 32'(S_IDLE));
    chk("t6_abortPauseRst", 32'(cpuReset), 32'd1);

    // Limit 2 to reach DONE with timeout, then abort+start together
    runLimit = 16'd2;
    startRun("t7");
    tick();
    tick();
    chk("t7_done", 32'(state), 32'(S_DONE));
    chk("t7_timeout", 32'(timeout), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("t7_abortWins", 32'(state), 32'(S_IDLE));
    chk("t7_timeoutClr", 32'(timeout), 32'd0);

    // Reset mid-RUN
    runLimit = 16'd0;
    startRun("t8");
    tick();
    tick();
    Reset = 1'b1;
    tick();
    chkResetVals("t8_midReset");
    Reset = 1'b0;

    // Saturation on the 4-bit counter instance
    startRun("t9");
    repeat (30) tick();
    chk("t9_satCount", 32'(cycleCountS), 32'd15);
    chk("t9_satEn", 32'(cpuClkEnS), 32'd1);
    chk("t9_satState", 32'(stateS), 32'(S_RUN));
    chk("t9_satDone", 32'(doneS), 32'd0);
    chk("t9_wideCount", 32'(cycleCount), 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
